fcvt_w_s_seq: RTL and testbench
===============================

Name: fcvt_w_s_seq

Overview:
- Sequential single-precision float to 32-bit integer converter (RISC-V FCVT.W.S / FCVT.WU.S) for the FPU execute path.
- Inverse of the existing int-to-float converter.
- Accepts one IEEE-754 operand over a valid/ready handshake, unpacks, aligns and rounds it over a fixed 4-cycle FSM, then presents the integer result with fflags, held until accepted.

Parameters:
- XLEN, 32, integer result width; only 32 is supported.
- FLEN, 32, float operand width; only 32 is supported.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  converter can accept; high only in IDLE.
- float_in  in  32  IEEE-754 single operand.
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101/110/111 treated as RTZ (dynamic rm is resolved upstream).
- is_unsigned  in  1  1 = FCVT.WU.S, 0 = FCVT.W.S.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- int_out  out  32  converted integer.
- fflags  out  5  {NV,DZ,OF,UF,NX}; only NV[4] and NX[0] are ever set.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, int_out=0, fflags=0, all internal registers cleared. Reset mid-operation discards the operation; no result is emitted.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid=1, capture float_in, rm, is_unsigned and go to UNPACK.
  - UNPACK: split sign/exp/frac; classify NaN, Inf, zero/subnormal, normal. Compute unbiased e = exp-127. Go to ALIGN.
  - ALIGN: place significand {1,frac} as a 32-bit integer part plus guard, round and sticky bits. For e<0, integer part = 0. For e>=23, left-shift by e-23 with GRS=0. Otherwise right-shift by 23-e, with sticky = OR of all bits below round. Go to ROUND.
  - ROUND: apply rounding increment per rm and sign to the magnitude, then negate if sign=1. Apply saturation and flags. Load int_out/fflags, assert out_valid, go to DONE.
  - DONE: hold int_out, fflags and out_valid stable while out_ready=0. On out_ready=1, clear out_valid and go to IDLE. No new operand is accepted in the same cycle.
- Latency: accept at edge N gives out_valid=1 after edge N+3. Throughput is at most one conversion per 5 cycles.
- Rounding increment, using guard g, sticky s (round|sticky) and LSB l:
  - RNE: g&(s|l).
  - RTZ: 0.
  - RDN: sign&(g|s).
  - RUP: ~sign&(g|s).
  - RMM: g.
- NX is set when g|s and no NV.
- Zero and subnormal inputs: result 0. NX=1 if frac!=0 and no increment; if incremented under RUP/RDN, result is +1 or -1.
- Signed range [-2^31, 2^31-1] after rounding:
  - Above range: 0x7FFFFFFF, NV=1.
  - Below range: 0x80000000, NV=1.
  - Exactly -2^31 (0xCF000000): 0x80000000 with no flags.
- Unsigned range [0, 2^32-1] after rounding:
  - Above range: 0xFFFFFFFF, NV=1.
  - Negative value rounding to <= -1: 0x00000000, NV=1.
  - Negative value rounding to 0: result 0, NX only.
- NaN (any payload, either sign): 0x7FFFFFFF signed / 0xFFFFFFFF unsigned, NV=1.
- +Inf saturates to max, -Inf to min (0x80000000 / 0x00000000), NV=1.
- When NV=1, NX=0. All overflow checks use a 33-bit magnitude, so a rounding carry is detected.
- in_valid while not IDLE is ignored; the upstream holds it.

Test Plan:
- 0x40600000 (3.5), rm=RNE, signed -> int_out=0x00000004, fflags=0x01, out_valid exactly 3 cycles after the accept edge.
- 0xC0200000 (-2.5): RNE -> 0xFFFFFFFE, NX; RDN -> 0xFFFFFFFD, NX; RTZ -> 0xFFFFFFFE, NX; RMM -> 0xFFFFFFFD, NX.
- Range limits:
  - 0xCF000000 signed -> 0x80000000, fflags=0.
  - 0x4F000000 signed -> 0x7FFFFFFF, NV (0x10).
  - 0x4F000000 unsigned -> 0x80000000, fflags=0.
  - 0x7F800000 unsigned -> 0xFFFFFFFF, NV.
- Specials:
  - 0x7FC00000 signed -> 0x7FFFFFFF, NV.
  - 0xBF000000 (-0.5) unsigned RDN -> 0, NV.
  - Same operand unsigned RTZ -> 0, NX.
  - 0x00000001 RUP -> 1, NX.
- Backpressure: hold out_ready=0 for 10 cycles -> int_out/fflags/out_valid stable and in_ready=0 throughout; release -> IDLE next cycle, next operand accepted.
- Assert rst_n=0 asynchronously in ALIGN -> out_valid=0 and in_ready=1 immediately, no stale result after reset release.

Source files
------------

// File: rtl/fcvt_w_s_seq.sv
// fcvt_w_s_seq: sequential single-precision float to 32-bit integer
// converter (FCVT.W.S / FCVT.WU.S). One operand is taken in IDLE, then
// UNPACK -> ALIGN -> ROUND each take one cycle, and the result is held in
// DONE until the consumer accepts it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE
// and int_out/fflags stay stable until out_ready is seen.
module fcvt_w_s_seq #(
  parameter int XLEN = 32,
  parameter int FLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FLEN-1:0] float_in,
  input  logic [2:0]      rm,
  input  logic            is_unsigned,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] int_out,
  output logic [4:0]      fflags
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // state is the observable FSM state for checkers bound to this module
  state_t state;
  state_t state_nxt;

  // captured operand
  logic [31:0]       op_q;
  logic [2:0]        rm_q;
  logic              uns_q;

  // unpacked fields
  logic              sign_q;
  logic              is_nan_q;
  logic              is_inf_q;
  logic              is_sub_q;
  logic              frac_nz_q;
  logic signed [8:0] e_q;
  logic [23:0]       sig_q;

  // aligned magnitude with guard/sticky; big_q marks |x| >= 2^32
  logic [31:0]       mag_q;
  logic              g_q;
  logic              s_q;
  logic              big_q;

  // unpack stage combinational values
  logic signed [8:0] u_e;
  logic              u_exp_max;
  logic              u_exp_zero;
  logic              u_frac_nz;

  // align stage combinational values
  logic [31:0]       a_mag;
  logic              a_g;
  logic              a_s;
  logic              a_big;
  logic [48:0]       a_tmp;
  logic [4:0]        a_lsh;
  logic [4:0]        a_rsh;

  // round stage combinational values
  logic              r_inc;
  logic              r_nv;
  logic              r_inexact;
  logic [32:0]       r_mag;
  logic [31:0]       r_res;
  logic [4:0]        r_flags;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic: fixed walk through the pipeline steps
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = S_ALIGN;
      S_ALIGN:  state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_DONE;
      S_DONE:   if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // handshake outputs decoded from the state register
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // split the operand into sign, unbiased exponent and class
  always_comb begin
    u_exp_max  = (op_q[30:23] == 8'hFF);
    u_exp_zero = (op_q[30:23] == 8'h00);
    u_frac_nz  = (op_q[22:0] != 23'd0);
    u_e        = $signed({1'b0, op_q[30:23]}) - 9'sd127;
  end

  // place {1,frac} as integer part plus guard and sticky
  always_comb begin
    a_mag = 32'd0;
    a_g   = 1'b0;
    a_s   = 1'b0;
    a_big = 1'b0;
    a_tmp = 49'd0;
    a_lsh = e_q[4:0] - 5'd23;
    a_rsh = 5'd23 - e_q[4:0];
    if (is_sub_q) begin
      // subnormals and zero lie below 2^-126, so only sticky can be set
      a_s = frac_nz_q;
    end else if (e_q < 9'sd0) begin
      if (e_q == -9'sd1) begin
        // value in [0.5,1): the hidden one is the guard bit
        a_g = 1'b1;
        a_s = frac_nz_q;
      end else begin
        a_s = 1'b1;
      end
    end else if (e_q >= 9'sd32) begin
      a_big = 1'b1;
    end else if (e_q >= 9'sd23) begin
      a_mag = {8'd0, sig_q} << a_lsh;
    end else begin
      a_tmp = {sig_q, 25'd0} >> a_rsh;
      a_mag = {8'd0, a_tmp[48:25]};
      a_g   = a_tmp[24];
      a_s   = |a_tmp[23:0];
    end
  end

  // rounding increment, sign application, saturation and flags
  always_comb begin
    case (rm_q)
      3'b000:  r_inc = g_q & (s_q | mag_q[0]);
      3'b010:  r_inc = sign_q & (g_q | s_q);
      3'b011:  r_inc = ~sign_q & (g_q | s_q);
      3'b100:  r_inc = g_q;
      default: r_inc = 1'b0;
    endcase
    r_mag     = {1'b0, mag_q} + {32'd0, r_inc};
    r_inexact = g_q | s_q;
    r_nv      = 1'b0;
    r_res     = 32'd0;
    if (is_nan_q) begin
      r_nv  = 1'b1;
      r_res = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    end else if (is_inf_q || big_q) begin
      r_nv = 1'b1;
      if (sign_q) r_res = uns_q ? 32'h0000_0000 : 32'h8000_0000;
      else        r_res = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    end else if (uns_q) begin
      if (sign_q) begin
        // any negative value that rounds away from zero is invalid
        r_nv  = (r_mag != 33'd0);
        r_res = 32'd0;
      end else if (r_mag[32]) begin
        r_nv  = 1'b1;
        r_res = 32'hFFFF_FFFF;
      end else begin
        r_res = r_mag[31:0];
      end
    end else begin
      if (sign_q) begin
        if (r_mag > 33'h0_8000_0000) begin
          r_nv  = 1'b1;
          r_res = 32'h8000_0000;
        end else begin
          r_res = 32'd0 - r_mag[31:0];
        end
      end else if (r_mag > 33'h0_7FFF_FFFF) begin
        r_nv  = 1'b1;
        r_res = 32'h7FFF_FFFF;
      end else begin
        r_res = r_mag[31:0];
      end
    end
    r_flags = {r_nv, 3'b000, r_inexact & ~r_nv};
  end

  // datapath registers loaded by the step that produces them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 32'd0;
      rm_q      <= 3'd0;
      uns_q     <= 1'b0;
      sign_q    <= 1'b0;
      is_nan_q  <= 1'b0;
      is_inf_q  <= 1'b0;
      is_sub_q  <= 1'b0;
      frac_nz_q <= 1'b0;
      e_q       <= 9'sd0;
      sig_q     <= 24'd0;
      mag_q     <= 32'd0;
      g_q       <= 1'b0;
      s_q       <= 1'b0;
      big_q     <= 1'b0;
      int_out   <= '0;
      fflags    <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= float_in;
            rm_q  <= rm;
            uns_q <= is_unsigned;
          end
        end
        S_UNPACK: begin
          sign_q    <= op_q[31];
          is_nan_q  <= u_exp_max & u_frac_nz;
          is_inf_q  <= u_exp_max & ~u_frac_nz;
          is_sub_q  <= u_exp_zero;
          frac_nz_q <= u_frac_nz;
          e_q       <= u_e;
          sig_q     <= {1'b1, op_q[22:0]};
        end
        S_ALIGN: begin
          mag_q <= a_mag;
          g_q   <= a_g;
          s_q   <= a_s;
          big_q <= a_big;
        end
        S_ROUND: begin
          int_out <= r_res;
          fflags  <= r_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fcvt_w_s_seq.sv
// Testbench for fcvt_w_s_seq: each operand's expected {int,flags} is queued
// when it is driven and popped when the converter presents its result.
module tb_fcvt_w_s_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] float_in;
  logic [2:0]  rm;
  logic        is_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic [4:0]  fflags;

  logic [36:0] exp_q[$];
  int          checks;
  int          passed;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;

  fcvt_w_s_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .float_in   (float_in),
    .rm         (rm),
    .is_unsigned(is_unsigned),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .int_out    (int_out),
    .fflags     (fflags)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one operand; returns just after the accepting edge
  task automatic drive_op(input logic [31:0] op, input logic [2:0] r,
                          input logic u, input logic [36:0] exp,
                          output bit to);
    int n;
    to = 0;
    n  = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      to = 1;
    end else begin
      in_valid    = 1'b1;
      float_in    = op;
      rm          = r;
      is_unsigned = u;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // wait for a result, sample it, then accept it for one cycle
  task automatic get_result(output logic [31:0] v, output logic [4:0] f,
                            output int lat, output bit to);
    lat = 0;
    to  = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    v = int_out;
    f = fflags;
    if (!out_valid) begin
      to = 1;
    end else begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else passed++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else passed++;
    checks++;
    if (int_out !== 32'd0) $display("FAIL reset_int_out: got %h expected 00000000", int_out);
    else passed++;
    checks++;
    if (fflags !== 5'd0) $display("FAIL reset_fflags: got %h expected 00", fflags);
    else passed++;
  endtask

  // run a table of vectors through the scoreboard
  task automatic run_vectors(input string name, input logic [31:0] ops[],
                             input logic [2:0] rms[], input logic us[],
                             input logic [36:0] exps[]);
    logic [31:0] v;
    logic [4:0]  f;
    logic [36:0] e;
    int lat;
    bit to;
    foreach (ops[i]) begin
      drive_op(ops[i], rms[i], us[i], exps[i], to);
      if (!to) get_result(v, f, lat, to);
      checks++;
      if (to) begin
        $display("FAIL %s[%0d]_timeout: got no result expected %h", name, i, exps[i]);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        e = exp_q.pop_front();
        if ({v, f} !== e)
          $display("FAIL %s[%0d]: got %h/%h expected %h/%h", name, i, v, f, e[36:5], e[4:0]);
        else passed++;
      end
    end
  endtask

  task automatic test_latency_rne();
    logic [31:0] v;
    logic [4:0]  f;
    logic [36:0] e;
    int lat;
    bit to;
    drive_op(32'h4060_0000, RNE, 1'b0, {32'h0000_0004, 5'h01}, to);
    if (!to) get_result(v, f, lat, to);
    checks++;
    if (to) begin
      $display("FAIL latency_timeout: got no result expected 00000004");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if ({v, f} !== e) $display("FAIL rne_3p5: got %h/%h expected %h/%h", v, f, e[36:5], e[4:0]);
      else passed++;
      checks++;
      if (lat !== 3) $display("FAIL latency: got %0d expected 3", lat);
      else passed++;
    end
  endtask

  task automatic test_rounding_modes();
    run_vectors("round_m2p5",
      '{32'hC020_0000, 32'hC020_0000, 32'hC020_0000, 32'hC020_0000, 32'h3FC0_0000},
      '{RNE, RDN, RTZ, RMM, RUP},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{{32'hFFFF_FFFE, 5'h01}, {32'hFFFF_FFFD, 5'h01}, {32'hFFFF_FFFE, 5'h01},
        {32'hFFFF_FFFD, 5'h01}, {32'h0000_0002, 5'h01}});
  endtask

  task automatic test_range_limits();
    run_vectors("range",
      '{32'hCF00_0000, 32'h4F00_0000, 32'h4F00_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h4F80_0000},
      '{RNE, RNE, RNE, RNE, RNE, RTZ},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
      '{{32'h8000_0000, 5'h00}, {32'h7FFF_FFFF, 5'h10}, {32'h8000_0000, 5'h00},
        {32'hFFFF_FFFF, 5'h10}, {32'h8000_0000, 5'h10}, {32'hFFFF_FFFF, 5'h10}});
  endtask

  task automatic test_specials();
    run_vectors("special",
      '{32'h7FC0_0000, 32'hBF00_0000, 32'hBF00_0000, 32'h0000_0001, 32'h8000_0001, 32'hFFC0_0001},
      '{RNE, RDN, RTZ, RUP, RDN, RNE},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
      '{{32'h7FFF_FFFF, 5'h10}, {32'h0000_0000, 5'h10}, {32'h0000_0000, 5'h01},
        {32'h0000_0001, 5'h01}, {32'hFFFF_FFFF, 5'h01}, {32'hFFFF_FFFF, 5'h10}});
  endtask

  // random exact integers: build the float from the integer, expect it back
  task automatic test_random_exact();
    logic [31:0] ops[];
    logic [2:0]  rms[];
    logic        us[];
    logic [36:0] exps[];
    int n, p;
    logic [31:0] mant;
    logic neg;
    ops = new[16]; rms = new[16]; us = new[16]; exps = new[16];
    for (int i = 0; i < 16; i++) begin
      n   = $urandom_range(1, 32'h7F_FFFF);
      neg = 1'($urandom_range(0, 1));
      p = 0;
      for (int b = 0; b < 23; b++) if (n[b]) p = b;
      mant = 32'(n) << (23 - p);
      ops[i]  = {neg, 8'(127 + p), mant[22:0]};
      rms[i]  = 3'($urandom_range(0, 4));
      us[i]   = 1'b0;
      exps[i] = {neg ? (32'd0 - 32'(n)) : 32'(n), 5'h00};
    end
    run_vectors("random_exact", ops, rms, us, exps);
  endtask

  task automatic test_backpressure();
    logic [31:0] v;
    logic [4:0]  f;
    logic [36:0] e;
    int lat;
    bit to;
    int n;
    drive_op(32'h4060_0000, RNE, 1'b0, {32'h0000_0004, 5'h01}, to);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b1 || int_out !== 32'h4 || fflags !== 5'h01 || in_ready !== 1'b0)
        $display("FAIL hold_cycle%0d: got v=%b %h/%h rdy=%b expected v=1 00000004/01 rdy=0",
                 c, out_valid, int_out, fflags, in_ready);
      else passed++;
      @(posedge clk);
      #1;
    end
    e = exp_q.pop_front();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL release_idle: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    else passed++;
    checks++;
    if (e !== {32'h4, 5'h01}) $display("FAIL hold_queue: got %h expected %h", e, {32'h4, 5'h01});
    else passed++;
    drive_op(32'h4120_0000, RTZ, 1'b1, {32'h0000_000A, 5'h00}, to);
    if (!to) get_result(v, f, lat, to);
    checks++;
    if (to) begin
      $display("FAIL after_release_timeout: got no result expected 0000000a");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if ({v, f} !== e) $display("FAIL after_release: got %h/%h expected %h/%h", v, f, e[36:5], e[4:0]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit seen;
    drive_op(32'h4060_0000, RNE, 1'b0, {32'h0000_0004, 5'h01}, to);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL async_reset: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    else passed++;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) $display("FAIL stale_result: got out_valid=1 expected 0");
    else passed++;
    checks++;
    if (int_out !== 32'd0) $display("FAIL reset_mid_int_out: got %h expected 00000000", int_out);
    else passed++;
  endtask

  initial begin
    checks      = 0;
    passed      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    float_in    = 32'd0;
    rm          = 3'd0;
    is_unsigned = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_latency_rne();
    test_rounding_modes();
    test_range_limits();
    test_specials();
    test_random_exact();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) $display("FAIL queue_empty: got %0d expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
